// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, the x0 constant and the write-back request type.
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests buffering LSU results.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(ENTRIES);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    wb_req_t       mem_q [ENTRIES];
    logic          do_push, do_pop;

    assign full    = count_q == ENTRIES[PW:0];
    assign empty   = count_q == '0;
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointers are power-of-two wide, so natural overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(do_push);
            rd_ptr_q <= rd_ptr_q + PW'(do_pop);
            count_q  <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU and LSU results onto the register-file write port
// and keeps a per-register pending scoreboard for RAW/WAW hazard detection.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int WIDTH    = XLEN,
    parameter int DEPTH    = NREGS,
    parameter int LSU_FIFO = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    input  logic [AW-1:0]    chk_addr0,
    input  logic [AW-1:0]    chk_addr1,
    output logic             chk_hazard0,
    output logic             chk_hazard1,
    output logic [AW-1:0]    wr_addr0,
    output logic [WIDTH-1:0] wr_din0,
    output logic             we_0,
    output logic             wb_err
);
    logic [DEPTH-1:0] pending_q, pending_d;
    logic             we_q, we_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_din_q, wr_din_d;
    logic             wb_err_q, wb_err_d;
    logic             fifo_full, fifo_empty, fifo_pop, sel_valid;
    wb_req_t          fifo_head, sel;

    wb_fifo #(.ENTRIES(LSU_FIFO)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lsu_valid),
        .pop   (fifo_pop),
        .din   (wb_req_t'{rd: lsu_rd, data: lsu_data}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A register being written this cycle is forwarded by the register file.
    function automatic logic wr_hit(input logic [AW-1:0] a);
        return we_q & (wr_addr_q == a);
    endfunction

    assign lsu_ready   = !fifo_full;
    assign issue_ready = !pending_q[issue_rd] | wr_hit(issue_rd) | (issue_rd == REG_X0);
    assign chk_hazard0 = pending_q[chk_addr0] & (chk_addr0 != REG_X0) & !wr_hit(chk_addr0);
    assign chk_hazard1 = pending_q[chk_addr1] & (chk_addr1 != REG_X0) & !wr_hit(chk_addr1);

    // ALU has no backpressure, so it always wins; the LSU buffer drains in idle cycles.
    assign fifo_pop  = !alu_valid & !fifo_empty;
    assign sel_valid = alu_valid | !fifo_empty;
    assign sel       = alu_valid ? wb_req_t'{rd: alu_rd, data: alu_data} : fifo_head;
    assign we_d      = sel_valid & (sel.rd != REG_X0);
    assign wr_addr_d = we_d ? sel.rd : wr_addr_q;
    assign wr_din_d  = we_d ? sel.data : wr_din_q;
    assign wb_err_d  = wb_err_q | (we_d & !pending_q[sel.rd]);

    always_comb begin
        pending_d = pending_q;
        if (we_q) pending_d[wr_addr_q] = 1'b0;
        if (issue_valid & issue_ready & (issue_rd != REG_X0)) pending_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_din_q  <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_din_q  <= wr_din_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign we_0     = we_q;
    assign wr_addr0 = wr_addr_q;
    assign wr_din0  = wr_din_q;
    assign wb_err   = wb_err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vector table plus a hand-written asynchronous reset sequence.
module tb_regfile_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0, alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  issue_rd = '0, alu_rd = '0, lsu_rd = '0, chk_addr0 = '0, chk_addr1 = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        issue_ready, lsu_ready, chk_hazard0, chk_hazard1, we_0, wb_err;
    logic [4:0]  wr_addr0;
    logic [31:0] wr_din0;
    int          tests = 0, fails = 0;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
        .chk_hazard0(chk_hazard0), .chk_hazard1(chk_hazard1),
        .wr_addr0(wr_addr0), .wr_din0(wr_din0), .we_0(we_0), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic [4:0] ird;
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic lv; logic [4:0] lrd; logic [31:0] ld;
        logic [4:0] c0, c1;
        logic ir, lr, h0, h1, we; logic [4:0] wa; logic [31:0] wd; logic err;
    } vec_t;

    vec_t v[$];

    function automatic void add(
        input logic iv, input int ird, input logic av, input int ard, input logic [31:0] ad,
        input logic lv, input int lrd, input logic [31:0] ld, input int c0, input int c1,
        input logic ir, input logic lr, input logic h0, input logic h1,
        input logic we, input int wa, input logic [31:0] wd, input logic err);
        vec_t r;
        r.iv = iv; r.ird = 5'(ird); r.av = av; r.ard = 5'(ard); r.ad = ad;
        r.lv = lv; r.lrd = 5'(lrd); r.ld = ld; r.c0 = 5'(c0); r.c1 = 5'(c1);
        r.ir = ir; r.lr = lr; r.h0 = h0; r.h1 = h1; r.we = we; r.wa = 5'(wa); r.wd = wd; r.err = err;
        v.push_back(r);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input int ird, input logic av, input int ard, input logic [31:0] ad,
                         input logic lv, input int lrd, input logic [31:0] ld, input int c0, input int c1);
        issue_valid = iv; issue_rd = 5'(ird); alu_valid = av; alu_rd = 5'(ard); alu_data = ad;
        lsu_valid = lv; lsu_rd = 5'(lrd); lsu_data = ld; chk_addr0 = 5'(c0); chk_addr1 = 5'(c1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // iv ird av ard adata lv lrd ldata c0 c1 | ir lr h0 h1 we wa wd err
        add(0,0, 0,0,0, 0,0,0, 5,0,   1,1,0,0, 0,0,0,0);
        add(1,5, 0,0,0, 0,0,0, 5,0,   1,1,0,0, 0,0,0,0);
        add(0,0, 1,5,32'hDEAD_BEEF, 0,0,0, 5,0, 1,1,1,0, 0,0,0,0);
        add(0,5, 0,0,0, 0,0,0, 5,0,   1,1,0,0, 1,5,32'hDEAD_BEEF,0);
        add(0,5, 0,0,0, 0,0,0, 5,0,   1,1,0,0, 0,5,32'hDEAD_BEEF,0);
        add(1,3, 0,0,0, 0,0,0, 3,0,   1,1,0,0, 0,5,32'hDEAD_BEEF,0);
        add(1,7, 0,0,0, 0,0,0, 3,7,   1,1,1,0, 0,5,32'hDEAD_BEEF,0);
        add(0,0, 1,3,32'h33, 1,7,32'h77, 3,7, 1,1,1,1, 0,5,32'hDEAD_BEEF,0);
        add(0,0, 0,0,0, 0,0,0, 3,7,   1,1,0,1, 1,3,32'h33,0);
        add(0,0, 0,0,0, 0,0,0, 3,7,   1,1,0,0, 1,7,32'h77,0);
        add(0,0, 0,0,0, 0,0,0, 3,7,   1,1,0,0, 0,7,32'h77,0);
        add(1,9, 0,0,0, 0,0,0, 9,0,   1,1,0,0, 0,7,32'h77,0);
        add(1,9, 1,9,32'h99, 0,0,0, 9,0, 0,1,1,0, 0,7,32'h77,0);
        add(1,9, 0,0,0, 0,0,0, 9,0,   1,1,0,0, 1,9,32'h99,0);
        add(0,9, 1,9,32'h100, 0,0,0, 9,0, 0,1,1,0, 0,9,32'h99,0);
        add(0,0, 0,0,0, 0,0,0, 9,0,   1,1,0,0, 1,9,32'h100,0);
        add(1,0, 1,0,32'hABC, 0,0,0, 0,0, 1,1,0,0, 0,9,32'h100,0);
        add(0,0, 0,0,0, 1,0,32'h5, 0,0, 1,1,0,0, 0,9,32'h100,0);
        add(0,0, 0,0,0, 0,0,0, 0,0,   1,1,0,0, 0,9,32'h100,0);
        add(0,0, 0,0,0, 0,0,0, 0,0,   1,1,0,0, 0,9,32'h100,0);
        add(1,10, 0,0,0, 0,0,0, 0,0,  1,1,0,0, 0,9,32'h100,0);
        add(1,11, 0,0,0, 0,0,0, 0,0,  1,1,0,0, 0,9,32'h100,0);
        add(1,13, 0,0,0, 0,0,0, 0,0,  1,1,0,0, 0,9,32'h100,0);
        add(1,14, 0,0,0, 0,0,0, 0,0,  1,1,0,0, 0,9,32'h100,0);
        add(1,15, 0,0,0, 0,0,0, 0,0,  1,1,0,0, 0,9,32'h100,0);
        add(0,0, 1,0,0, 1,10,32'hA0, 10,15, 1,1,1,1, 0,9,32'h100,0);
        add(0,0, 1,0,0, 1,11,32'hB0, 10,15, 1,1,1,1, 0,9,32'h100,0);
        add(0,0, 1,0,0, 1,13,32'hD0, 10,15, 1,1,1,1, 0,9,32'h100,0);
        add(0,0, 1,0,0, 1,14,32'hE0, 10,15, 1,1,1,1, 0,9,32'h100,0);
        add(0,0, 1,0,0, 1,15,32'hF0, 10,15, 1,0,1,1, 0,9,32'h100,0);
        add(0,0, 0,0,0, 1,15,32'hF0, 10,15, 1,0,1,1, 0,9,32'h100,0);
        add(0,0, 0,0,0, 1,15,32'hF0, 10,11, 1,1,0,1, 1,10,32'hA0,0);
        add(0,0, 0,0,0, 0,0,0, 11,13, 1,1,0,1, 1,11,32'hB0,0);
        add(0,0, 0,0,0, 0,0,0, 13,15, 1,1,0,1, 1,13,32'hD0,0);
        add(0,0, 0,0,0, 0,0,0, 14,15, 1,1,0,1, 1,14,32'hE0,0);
        add(0,0, 0,0,0, 0,0,0, 15,10, 1,1,0,0, 1,15,32'hF0,0);
        add(0,0, 0,0,0, 0,0,0, 15,10, 1,1,0,0, 0,15,32'hF0,0);
        add(0,0, 1,12,32'hC, 0,0,0, 0,0, 1,1,0,0, 0,15,32'hF0,0);
        add(0,0, 0,0,0, 0,0,0, 0,0,   1,1,0,0, 1,12,32'hC,1);
        add(0,0, 0,0,0, 0,0,0, 0,0,   1,1,0,0, 0,12,32'hC,1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        foreach (v[i]) begin
            drive(v[i].iv, v[i].ird, v[i].av, v[i].ard, v[i].ad, v[i].lv, v[i].lrd, v[i].ld, v[i].c0, v[i].c1);
            #1;
            chk("issue_ready", i, issue_ready, v[i].ir);
            chk("lsu_ready", i, lsu_ready, v[i].lr);
            chk("chk_hazard0", i, chk_hazard0, v[i].h0);
            chk("chk_hazard1", i, chk_hazard1, v[i].h1);
            chk("we_0", i, we_0, v[i].we);
            chk("wr_addr0", i, wr_addr0, v[i].wa);
            chk("wr_din0", i, wr_din0, v[i].wd);
            chk("wb_err", i, wb_err, v[i].err);
            step();
        end

        // Asynchronous reset with two buffered LSU results, live reservations and a write in flight.
        drive(1,20, 0,0,0, 0,0,0, 0,0); step();
        drive(1,21, 0,0,0, 0,0,0, 0,0); step();
        drive(1,22, 0,0,0, 0,0,0, 0,0); step();
        drive(0,0, 1,0,0, 1,20,32'h20, 0,0); step();
        drive(0,0, 1,0,0, 1,21,32'h21, 0,0); step();
        drive(0,0, 1,22,32'h22, 0,0,0, 0,0); step();
        drive(0,20, 0,0,0, 0,0,0, 20,21);
        #1;
        chk("pre_rst_we_0", 100, we_0, 1'b1);
        chk("pre_rst_hazard0", 100, chk_hazard0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rst_we_0", 101, we_0, 1'b0);
        chk("rst_wr_addr0", 101, wr_addr0, 5'd0);
        chk("rst_wr_din0", 101, wr_din0, 32'd0);
        chk("rst_wb_err", 101, wb_err, 1'b0);
        chk("rst_hazard0", 101, chk_hazard0, 1'b0);
        chk("rst_hazard1", 101, chk_hazard1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_we_0", 102 + k, we_0, 1'b0);
            chk("post_rst_lsu_ready", 102 + k, lsu_ready, 1'b1);
            chk("post_rst_hazard0", 102 + k, chk_hazard0, 1'b0);
            chk("post_rst_hazard1", 102 + k, chk_hazard1, 1'b0);
            chk("post_rst_issue_ready", 102 + k, issue_ready, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
